xor_parity_accum: RTL and testbench

//   Streaming, parametrised successor to the 2-input XOR gate. Folds a packet of

---
 rtl/xor_parity_accum.sv | 79 +++++++
 tb/tb_xor_parity_accum.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_accum.sv
// Streaming XOR parity accumulator: folds a valid/ready packet of WIDTH-bit words
// into a parity word, parity bit and saturating word count, held until taken.
module xor_parity_accum #(
  parameter int WIDTH      = 8,
  parameter int MAX_WORDS  = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               InValid,
  output logic                               InReady,
  input  logic [WIDTH-1:0]                   InData,
  input  logic                               InLast,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic [WIDTH-1:0]                   OutParityWord,
  output logic                               OutParityBit,
  output logic [$clog2(MAX_WORDS+1)-1:0]     OutCount,
  output logic                               OutOverflow
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             out_valid;
  logic             accept;

  // Ready is a function of state alone so upstream may wait on it before asserting valid.
  assign InReady = (state != DONE) & ~Rst;
  assign accept  = InValid & InReady;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc       <= InData;
          cnt       <= CW'(1);
          state     <= InLast ? DONE : ACCUM;
          out_valid <= InLast;
        end
        ACCUM: if (accept) begin
          // Words past the limit still fold into the parity; only the count saturates.
          acc <= acc ^ InData;
          if (cnt == MAX_CNT) ovf <= 1'b1;
          else                cnt <= cnt + CW'(1);
          state     <= InLast ? DONE : ACCUM;
          out_valid <= InLast;
        end
        DONE: if (OutReady) begin
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign OutValid      = out_valid;
  assign OutParityWord = acc;
  assign OutCount      = cnt;
  assign OutOverflow   = ovf;
  assign OutParityBit  = (^acc) ^ 1'(PARITY_ODD);

endmodule

// File: tb/tb_xor_parity_accum.sv
// Bench for xor_parity_accum: three variants (even/16, odd/16, even/4) share one
// stimulus stream and are checked against a queue-based packet model.
module tb_xor_parity_accum;

  localparam int MAXW [3] = '{16, 16, 4};
  localparam int ODD  [3] = '{0, 1, 0};

  logic       Clk = 1'b0;
  logic       Rst, InValid, InLast, OutReady;
  logic [7:0] InData;

  logic [2:0] ird, ov, ob, oovf;
  logic [7:0] ow [3];
  logic [4:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic [4:0] oc [3];

  int checks = 0;
  int errors = 0;
  logic [7:0] pkt [$];

  always #5 Clk = ~Clk;

  xor_parity_accum #(.WIDTH(8), .MAX_WORDS(16), .PARITY_ODD(0)) u_a (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(ird[0]), .InData(InData),
    .InLast(InLast), .OutValid(ov[0]), .OutReady(OutReady), .OutParityWord(ow[0]),
    .OutParityBit(ob[0]), .OutCount(cnt_a), .OutOverflow(oovf[0]));
  xor_parity_accum #(.WIDTH(8), .MAX_WORDS(16), .PARITY_ODD(1)) u_b (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(ird[1]), .InData(InData),
    .InLast(InLast), .OutValid(ov[1]), .OutReady(OutReady), .OutParityWord(ow[1]),
    .OutParityBit(ob[1]), .OutCount(cnt_b), .OutOverflow(oovf[1]));
  xor_parity_accum #(.WIDTH(8), .MAX_WORDS(4), .PARITY_ODD(0)) u_c (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(ird[2]), .InData(InData),
    .InLast(InLast), .OutValid(ov[2]), .OutReady(OutReady), .OutParityWord(ow[2]),
    .OutParityBit(ob[2]), .OutCount(cnt_c), .OutOverflow(oovf[2]));

  always_comb begin
    oc[0] = cnt_a;
    oc[1] = cnt_b;
    oc[2] = {2'b00, cnt_c};
  end

  // Reference model: packet contents in a queue, results from plain arithmetic.
  function automatic logic [7:0] ew();
    logic [7:0] x = 8'h00;
    foreach (pkt[k]) x = x ^ pkt[k];
    return x;
  endfunction
  function automatic logic eb(int i);
    return 1'(($countones(ew()) + ODD[i]) % 2);
  endfunction
  function automatic logic [4:0] ec(int i);
    int n = pkt.size();
    return 5'((n > MAXW[i]) ? MAXW[i] : n);
  endfunction
  function automatic logic eo(int i);
    return pkt.size() > MAXW[i];
  endfunction

  // Offers one word after `gap` idle cycles (idle cycles carry junk data/last).
  task automatic send_word(input logic [7:0] d, input logic l, input int gap);
    bit ok = 0;
    for (int g = 0; g < gap; g++) begin
      InValid = 1'b0; InData = 8'($urandom); InLast = 1'($urandom);
      @(posedge Clk); #1;
    end
    InValid = 1'b1; InData = d; InLast = l;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge Clk); ok = ird[0];
      @(posedge Clk); #1;
    end
    InValid = 1'b0; InLast = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout data=%h InReady=%b required 1", d, ird);
    end else pkt.push_back(d);
  endtask

  task automatic take_result();
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    pkt.delete();
  endtask

  task automatic test_reset();
    Rst = 1'b1; InValid = 1'b0; InLast = 1'b0; InData = 8'h00; OutReady = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || ow[i] !== 8'h00 || ob[i] !== 1'(ODD[i]) || oc[i] !== 5'd0 ||
          oovf[i] !== 1'b0 || ird[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d v=%b w=%h b=%b c=%0d o=%b rdy=%b required 0 00 %0d 0 0 0",
                 i, ov[i], ow[i], ob[i], oc[i], oovf[i], ird[i], ODD[i]);
      end
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (ird !== 3'b111 || ov !== 3'b000) begin
      errors++;
      $display("FAIL reset_release InReady=%b OutValid=%b required 111 000", ird, ov);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_single();
    send_word(8'hA5, 1'b1, 0);
    @(negedge Clk);
    checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 8'hA5 || ob[0] !== 1'b0 || oc[0] !== 5'd1 || ird[0] !== 1'b0) begin
      errors++;
      $display("FAIL single v=%b w=%h b=%b c=%0d rdy=%b required 1 a5 0 1 0",
               ov[0], ow[0], ob[0], oc[0], ird[0]);
    end
    @(posedge Clk); #1;
    take_result();
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || ow[i] !== 8'h00 || oc[i] !== 5'd0 || oovf[i] !== 1'b0 || ird[i] !== 1'b1) begin
        errors++;
        $display("FAIL after_result dut%0d v=%b w=%h c=%0d o=%b rdy=%b required 0 00 0 0 1",
                 i, ov[i], ow[i], oc[i], oovf[i], ird[i]);
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_gaps();
    send_word(8'h0F, 1'b0, 0);
    send_word(8'hF0, 1'b0, 2);
    send_word(8'h01, 1'b1, 2);
    @(negedge Clk);
    checks++;
    if (ow[0] !== 8'hFE || ob[0] !== 1'b1 || ob[1] !== 1'b0 || oc[0] !== 5'd3 || oovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL gaps w=%h b_even=%b b_odd=%b c=%0d o=%b required fe 1 0 3 0",
               ow[0], ob[0], ob[1], oc[0], oovf[0]);
    end
    @(posedge Clk); #1;
    take_result();
  endtask

  task automatic test_hold_done();
    send_word(8'h3C, 1'b0, 1);
    send_word(8'h81, 1'b1, 0);
    for (int c = 0; c < 5; c++) begin
      InValid = 1'b1; InData = 8'($urandom); InLast = 1'b1; OutReady = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ov[i] !== 1'b1 || ow[i] !== ew() || ob[i] !== eb(i) || oc[i] !== ec(i) || ird[i] !== 1'b0) begin
          errors++;
          $display("FAIL hold_done cyc%0d dut%0d v=%b w=%h b=%b c=%0d rdy=%b required 1 %h %b %0d 0",
                   c, i, ov[i], ow[i], ob[i], oc[i], ird[i], ew(), eb(i), ec(i));
        end
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0; InLast = 1'b0;
    take_result();
    @(negedge Clk);
    checks++;
    if (ird !== 3'b111 || ov !== 3'b000) begin
      errors++;
      $display("FAIL hold_release InReady=%b OutValid=%b required 111 000", ird, ov);
    end
    @(posedge Clk); #1;
    send_word(8'h5A, 1'b0, 0);
    send_word(8'h66, 1'b1, 0);
    @(negedge Clk);
    checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 8'h3C || oc[0] !== 5'd2) begin
      errors++;
      $display("FAIL hold_next v=%b w=%h c=%0d required 1 3c 2", ov[0], ow[0], oc[0]);
    end
    @(posedge Clk); #1;
    take_result();
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 6; k++) send_word(8'(k), k == 6, 0);
    @(negedge Clk);
    checks++;
    if (ow[2] !== 8'h07 || oc[2] !== 5'd4 || oovf[2] !== 1'b1 ||
        oc[0] !== 5'd6 || oovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL overflow max4 w=%h c=%0d o=%b max16 c=%0d o=%b required 07 4 1 6 0",
               ow[2], oc[2], oovf[2], oc[0], oovf[0]);
    end
    @(posedge Clk); #1;
    take_result();
  endtask

  task automatic test_reset_mid();
    send_word(8'h11, 1'b0, 0);
    send_word(8'h22, 1'b0, 0);
    Rst = 1'b1;
    #2;
    checks++;
    if (ird !== 3'b000 || ov !== 3'b000 || ow[0] !== 8'h00 || oc[0] !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_async InReady=%b OutValid=%b w=%h c=%0d required 000 000 00 0",
               ird, ov, ow[0], oc[0]);
    end
    pkt.delete();
    @(posedge Clk); #1;
    Rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      checks++;
      if (ov !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_stale OutValid=%b required 000", ov);
      end
      @(posedge Clk); #1;
    end
    send_word(8'h33, 1'b1, 0);
    @(negedge Clk);
    checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 8'h33 || oc[0] !== 5'd1 || oovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next v=%b w=%h c=%0d o=%b required 1 33 1 0",
               ov[0], ow[0], oc[0], oovf[0]);
    end
    @(posedge Clk); #1;
    take_result();
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      int n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++)
        send_word(8'($urandom), k == n - 1, $urandom_range(0, 2));
      // Result stays valid and stable however long downstream stalls.
      for (int w = $urandom_range(0, 3); w >= 0; w--) begin
        @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (ov[i] !== 1'b1 || ow[i] !== ew() || ob[i] !== eb(i) || oc[i] !== ec(i) || oovf[i] !== eo(i)) begin
            errors++;
            $display("FAIL random pkt%0d dut%0d v=%b w=%h b=%b c=%0d o=%b required 1 %h %b %0d %b",
                     p, i, ov[i], ow[i], ob[i], oc[i], oovf[i], ew(), eb(i), ec(i), eo(i));
          end
        end
        @(posedge Clk); #1;
      end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    // Next packet offered immediately with OutReady held high throughout.
    OutReady = 1'b1;
    send_word(8'hC3, 1'b1, 0);
    @(negedge Clk);
    checks++;
    if (ov[0] !== 1'b1 || ow[0] !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_first v=%b w=%h required 1 c3", ov[0], ow[0]);
    end
    pkt.delete();
    @(posedge Clk); #1;
    send_word(8'h96, 1'b1, 0);
    @(negedge Clk);
    checks++;
    if (ov[1] !== 1'b1 || ow[1] !== 8'h96 || ob[1] !== 1'b1 || oc[1] !== 5'd1) begin
      errors++;
      $display("FAIL b2b_second v=%b w=%h b=%b c=%0d required 1 96 1 1", ov[1], ow[1], ob[1], oc[1]);
    end
    @(posedge Clk); #1;
    OutReady = 1'b0;
    pkt.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_hold_done();
    test_overflow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
